// File: rtl/switch_ingress_packer.sv
// Per-port ingress front end: buffers local packets, tags them {valid, rx, tx, data} for the fabric.
// Latency: two edges from accepted transfer to port_out; in_ready drops only when the buffer is full.
module switch_ingress_packer #(
   parameter int PORT_ID        = 0,
   parameter int PORT_NUB_TOTAL = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int STALL_LIMIT    = 64,
   localparam int WIDTH_SEL     = $clog2(PORT_NUB_TOTAL),
   localparam int AW            = $clog2(FIFO_DEPTH),
   localparam int OUT_W         = 1 + 2*WIDTH_SEL + DATA_WIDTH,
   localparam int HW            = $clog2(STALL_LIMIT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH_SEL-1:0]  in_dest,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [OUT_W-1:0]      port_out,
   input  logic                  grant,
   output logic [AW:0]           fifo_count,
   output logic [15:0]           drop_cnt,
   output logic                  hol_stall
);

   // Destinations the per-destination filters will accept: in range and not ourselves.
   function automatic logic [(1<<WIDTH_SEL)-1:0] dest_ok_mask();
      logic [(1<<WIDTH_SEL)-1:0] m;
      m = '0;
      for (int i = 0; i < (1 << WIDTH_SEL); i++) begin
         m[i] = (i < PORT_NUB_TOTAL) && (i != PORT_ID);
      end
      return m;
   endfunction

   localparam logic [(1<<WIDTH_SEL)-1:0] DEST_OK = dest_ok_mask();
   localparam logic [WIDTH_SEL-1:0]      TX_ID   = WIDTH_SEL'(PORT_ID);
   localparam logic [AW:0]               DEPTH_C = (AW+1)'(FIFO_DEPTH);
   localparam logic [HW-1:0]             STALL_C = HW'(STALL_LIMIT);

   logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [WIDTH_SEL-1:0]  mem_dest [FIFO_DEPTH];
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr_inc;
   logic [AW:0]           count;
   logic [HW-1:0]         hol_cnt;
   logic [HW-1:0]         hol_nxt;
   logic [OUT_W-1:0]      out_nxt;
   logic                  xfer;
   logic                  push;
   logic                  drop;
   logic                  pop;

   assign in_ready   = (count < DEPTH_C) && !rst;
   assign xfer       = in_valid && in_ready;
   assign push       = xfer && DEST_OK[in_dest];
   assign drop       = xfer && !DEST_OK[in_dest];
   assign pop        = grant && port_out[OUT_W-1];
   assign rd_ptr_inc = rd_ptr + 1'b1;
   assign fifo_count = count;

   // After a pop the successor is shown immediately; with a single entry left that
   // successor can only be the packet being pushed on the same edge.
   always_comb begin
      out_nxt = '0;
      if (pop) begin
         if (count > (AW+1)'(1)) begin
            out_nxt = {1'b1, mem_dest[rd_ptr_inc], TX_ID, mem_data[rd_ptr_inc]};
         end else if (push) begin
            out_nxt = {1'b1, in_dest, TX_ID, in_data};
         end
      end else if (count != '0) begin
         out_nxt = {1'b1, mem_dest[rd_ptr], TX_ID, mem_data[rd_ptr]};
      end
   end

   always_comb begin
      hol_nxt = hol_cnt;
      if (pop || count == '0) begin
         hol_nxt = '0;
      end else if (port_out[OUT_W-1] && hol_cnt != STALL_C) begin
         hol_nxt = hol_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         port_out  <= '0;
         drop_cnt  <= '0;
         hol_cnt   <= '0;
         hol_stall <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr_inc;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         port_out <= out_nxt;
         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         hol_cnt   <= hol_nxt;
         hol_stall <= (hol_nxt == STALL_C);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= in_data;
         mem_dest[wr_ptr] <= in_dest;
      end
   end

endmodule
